mem_port_arbiter: RTL and testbench

- Shares a single SRAM-like memory port between the fetch stage (read-only) and the memory stage (load/store).
- Sequences one outstanding transaction at a time.
- Returns read data to the owning requester.
- Generates stall_if and stall_mem to the hazard logic so the pipeline freezes while a requester waits.
- Sits between the core datapath and the bus bridge.

---
 rtl/cpu_defines.sv | 18 +
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defines.sv
// Shared encodings for the memory-port arbiter.
//   arbState_t : bus sequencing state (IDLE, REQ, WAIT)
//   owner_t    : which pipeline stage owns the in-flight transaction
package cpu_defines;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arbState_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one SRAM-like bus port between instruction fetch (read-only) and
// the memory stage (load/store). One transaction is in flight at a time.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; arbitrate among current requests
// REQ   | bus_req high with latched payload, waiting for bus_addr_ok
// WAIT  | address accepted, waiting for bus_data_ok (may re-arbitrate)
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   inst_req/addr/cancel           fetch request, address, flush pulse
//   inst_rdata/valid               fetch response
//   data_req/wr/wstrb/addr/wdata   load/store request
//   data_rdata/valid               load/store response
//   bus_req/wr/wstrb/addr/wdata    bus address phase (driven from registers)
//   bus_addr_ok/data_ok/rdata      bus handshakes and read data
//   stall_if, stall_mem            pipeline hold requests
module mem_port_arbiter
  import cpu_defines::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_cancel,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_valid,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_valid,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int STRB_W = DATA_W / 8;

  arbState_t         stateQ, stateD;
  owner_t            ownerQ, ownerD;
  logic              cancelQ, cancelD;
  logic              busWrQ, busWrD;
  logic [STRB_W-1:0] busWstrbQ, busWstrbD;
  logic [ADDR_W-1:0] busAddrQ, busAddrD;
  logic [DATA_W-1:0] busWdataQ, busWdataD;

  logic complete;
  logic arbOpen;
  logic dataEligible;
  logic instEligible;

  // The requester finishing this cycle still holds its request line, so it
  // is excluded to avoid re-issuing the same access back-to-back.
  always_comb begin
    complete     = (stateQ == WAIT) && bus_data_ok;
    arbOpen      = (stateQ == IDLE) || complete;
    dataEligible = data_req && !(complete && ownerQ == DATA);
    instEligible = inst_req && !(complete && ownerQ == INST);
  end

  always_comb begin
    stateD    = stateQ;
    ownerD    = ownerQ;
    cancelD   = cancelQ;
    busWrD    = busWrQ;
    busWstrbD = busWstrbQ;
    busAddrD  = busAddrQ;
    busWdataD = busWdataQ;

    case (stateQ)
      REQ:     if (bus_addr_ok) stateD = WAIT;
      WAIT:    ;
      IDLE:    ;
      default: stateD = IDLE;
    endcase

    if (arbOpen) begin
      stateD = IDLE;
      ownerD = NONE;
      if (dataEligible) begin
        stateD    = REQ;
        ownerD    = DATA;
        busWrD    = data_wr;
        busWstrbD = data_wstrb;
        busAddrD  = data_addr;
        busWdataD = data_wdata;
      end else if (instEligible) begin
        stateD    = REQ;
        ownerD    = INST;
        busWrD    = 1'b0;
        busWstrbD = '0;
        busAddrD  = inst_addr;
        busWdataD = '0;
      end
    end

    // A flushed fetch still finishes on the bus; the flag only suppresses
    // its response and is dropped when that transaction ends.
    if (complete) begin
      cancelD = 1'b0;
    end else if (inst_cancel && ownerQ == INST && stateQ != IDLE) begin
      cancelD = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= IDLE;
      ownerQ    <= NONE;
      cancelQ   <= 1'b0;
      busWrQ    <= 1'b0;
      busWstrbQ <= '0;
      busAddrQ  <= '0;
      busWdataQ <= '0;
    end else begin
      stateQ    <= stateD;
      ownerQ    <= ownerD;
      cancelQ   <= cancelD;
      busWrQ    <= busWrD;
      busWstrbQ <= busWstrbD;
      busAddrQ  <= busAddrD;
      busWdataQ <= busWdataD;
    end
  end

  assign bus_req   = (stateQ == REQ);
  assign bus_wr    = busWrQ;
  assign bus_wstrb = busWstrbQ;
  assign bus_addr  = busAddrQ;
  assign bus_wdata = busWdataQ;

  assign inst_valid = complete && ownerQ == INST && !cancelQ && !inst_cancel;
  assign data_valid = complete && ownerQ == DATA;
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  assign stall_if  = inst_req & ~inst_valid;
  assign stall_mem = data_req & ~data_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized requesters and a randomized bus slave, all checked every cycle
// against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic [31:0] inst_rdata;
  logic        inst_valid;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stall_if;
  logic        stall_mem;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_rdata(inst_rdata), .inst_valid(inst_valid),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_valid(data_valid),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errCount = 0;
  int checkCount = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one granted transaction at a time, data before fetch,
  // the finishing requester skipped, flushed fetches complete silently.
  logic        mBusy = 1'b0;
  logic        mAcc = 1'b0;
  logic        mIsData = 1'b0;
  logic        mCancel = 1'b0;
  logic        mWr = 1'b0;
  logic [3:0]  mStrb = 4'h0;
  logic [31:0] mAddr = 32'h0;
  logic [31:0] mWdata = 32'h0;
  logic        expReq, done, expIv, expDv, dataEl, instEl;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        checkEq("rst_bus_req", 64'(bus_req), 64'(1'b0));
        checkEq("rst_inst_valid", 64'(inst_valid), 64'(1'b0));
        checkEq("rst_data_valid", 64'(data_valid), 64'(1'b0));
        mBusy = 1'b0;
        mAcc = 1'b0;
        mCancel = 1'b0;
      end else begin
        expReq = mBusy && !mAcc;
        done   = mBusy && mAcc && bus_data_ok;
        expIv  = done && !mIsData && !mCancel && !inst_cancel;
        expDv  = done && mIsData;
        checkEq("m_bus_req", 64'(bus_req), 64'(expReq));
        if (expReq) begin
          checkEq("m_bus_addr", 64'(bus_addr), 64'(mAddr));
          checkEq("m_bus_wr", 64'(bus_wr), 64'(mWr));
          checkEq("m_bus_wstrb", 64'(bus_wstrb), 64'(mStrb));
          if (mIsData) checkEq("m_bus_wdata", 64'(bus_wdata), 64'(mWdata));
        end
        checkEq("m_inst_valid", 64'(inst_valid), 64'(expIv));
        checkEq("m_data_valid", 64'(data_valid), 64'(expDv));
        if (expIv) checkEq("m_inst_rdata", 64'(inst_rdata), 64'(bus_rdata));
        if (expDv && !mWr) checkEq("m_data_rdata", 64'(data_rdata), 64'(bus_rdata));
        checkEq("m_stall_if", 64'(stall_if), 64'(inst_req && !expIv));
        checkEq("m_stall_mem", 64'(stall_mem), 64'(data_req && !expDv));

        if (expReq && bus_addr_ok) mAcc = 1'b1;
        if (mBusy && !mIsData && inst_cancel && !done) mCancel = 1'b1;
        dataEl = data_req && !(done && mIsData);
        instEl = inst_req && !(done && !mIsData);
        if (done) begin
          mBusy = 1'b0;
          mCancel = 1'b0;
        end
        if (!mBusy) begin
          if (dataEl) begin
            mBusy = 1'b1; mAcc = 1'b0; mIsData = 1'b1;
            mWr = data_wr; mStrb = data_wstrb; mAddr = data_addr; mWdata = data_wdata;
          end else if (instEl) begin
            mBusy = 1'b1; mAcc = 1'b0; mIsData = 1'b0;
            mWr = 1'b0; mStrb = 4'h0; mAddr = inst_addr; mWdata = 32'h0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    inst_req = 1'b0; inst_addr = 32'h0; inst_cancel = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
  endtask

  task automatic fetchAlone();
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; #1;
    checkEq("fa_c0_bus_req", 64'(bus_req), 64'(1'b0));
    checkEq("fa_c0_stall_if", 64'(stall_if), 64'(1'b1));
    step(); bus_addr_ok = 1'b1; #1;
    checkEq("fa_c1_bus_req", 64'(bus_req), 64'(1'b1));
    checkEq("fa_c1_bus_addr", 64'(bus_addr), 64'(32'hBFC0_0000));
    checkEq("fa_c1_stall_if", 64'(stall_if), 64'(1'b1));
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2408_0001; #1;
    checkEq("fa_c2_bus_req", 64'(bus_req), 64'(1'b0));
    checkEq("fa_c2_inst_valid", 64'(inst_valid), 64'(1'b1));
    checkEq("fa_c2_inst_rdata", 64'(inst_rdata), 64'(32'h2408_0001));
    checkEq("fa_c2_stall_if", 64'(stall_if), 64'(1'b0));
    step(); clearInputs(); #1;
    checkEq("fa_c3_inst_valid", 64'(inst_valid), 64'(1'b0));
  endtask

  task automatic contention();
    step();
    inst_req = 1'b1; inst_addr = 32'h8000_0020;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_1000; #1;
    checkEq("ct_c0_stall_if", 64'(stall_if), 64'(1'b1));
    step(); bus_addr_ok = 1'b1; #1;
    checkEq("ct_c1_bus_addr", 64'(bus_addr), 64'(32'h8000_1000));
    checkEq("ct_c1_bus_wr", 64'(bus_wr), 64'(1'b0));
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1357_2468; #1;
    checkEq("ct_c2_data_valid", 64'(data_valid), 64'(1'b1));
    checkEq("ct_c2_data_rdata", 64'(data_rdata), 64'(32'h1357_2468));
    checkEq("ct_c2_inst_valid", 64'(inst_valid), 64'(1'b0));
    checkEq("ct_c2_stall_if", 64'(stall_if), 64'(1'b1));
    step(); bus_data_ok = 1'b0; data_req = 1'b0; #1;
    checkEq("ct_c3_bus_req", 64'(bus_req), 64'(1'b1));
    checkEq("ct_c3_bus_addr", 64'(bus_addr), 64'(32'h8000_0020));
    checkEq("ct_c3_bus_wstrb", 64'(bus_wstrb), 64'(4'h0));
    checkEq("ct_c3_stall_if", 64'(stall_if), 64'(1'b1));
    step(); bus_addr_ok = 1'b1; #1;
    checkEq("ct_c4_stall_if", 64'(stall_if), 64'(1'b1));
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_0001; #1;
    checkEq("ct_c5_inst_valid", 64'(inst_valid), 64'(1'b1));
    checkEq("ct_c5_inst_rdata", 64'(inst_rdata), 64'(32'hCAFE_0001));
    step(); clearInputs(); #1;
  endtask

  task automatic storeSlowAccept();
    step();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_wdata = 32'hDEAD_BEEF; data_addr = 32'h8000_0004; #1;
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      checkEq("st_hold_bus_req", 64'(bus_req), 64'(1'b1));
      checkEq("st_hold_bus_addr", 64'(bus_addr), 64'(32'h8000_0004));
      checkEq("st_hold_bus_wdata", 64'(bus_wdata), 64'(32'hDEAD_BEEF));
      checkEq("st_hold_bus_wstrb", 64'(bus_wstrb), 64'(4'b0011));
      checkEq("st_hold_bus_wr", 64'(bus_wr), 64'(1'b1));
    end
    step(); bus_addr_ok = 1'b1; #1;
    checkEq("st_acc_bus_addr", 64'(bus_addr), 64'(32'h8000_0004));
    step(); bus_addr_ok = 1'b0; #1;
    checkEq("st_wait_data_valid", 64'(data_valid), 64'(1'b0));
    step(); bus_data_ok = 1'b1; #1;
    checkEq("st_done_data_valid", 64'(data_valid), 64'(1'b1));
    checkEq("st_done_stall_mem", 64'(stall_mem), 64'(1'b0));
    step(); clearInputs(); #1;
    checkEq("st_after_data_valid", 64'(data_valid), 64'(1'b0));
    checkEq("st_after_bus_req", 64'(bus_req), 64'(1'b0));
  endtask

  task automatic cancelFetch();
    step(); inst_req = 1'b1; inst_addr = 32'h8000_0010; #1;
    step(); bus_addr_ok = 1'b1; #1;
    checkEq("cn_bus_addr", 64'(bus_addr), 64'(32'h8000_0010));
    step(); bus_addr_ok = 1'b0; inst_cancel = 1'b1; inst_req = 1'b0; #1;
    step(); inst_cancel = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
    inst_req = 1'b1; inst_addr = 32'h8000_0100; #1;
    checkEq("cn_drop_inst_valid", 64'(inst_valid), 64'(1'b0));
    checkEq("cn_drop_stall_if", 64'(stall_if), 64'(1'b1));
    step(); bus_data_ok = 1'b0; #1;
    checkEq("cn_idle_bus_req", 64'(bus_req), 64'(1'b0));
    step(); bus_addr_ok = 1'b1; #1;
    checkEq("cn_new_bus_req", 64'(bus_req), 64'(1'b1));
    checkEq("cn_new_bus_addr", 64'(bus_addr), 64'(32'h8000_0100));
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3333_4444; #1;
    checkEq("cn_new_inst_valid", 64'(inst_valid), 64'(1'b1));
    checkEq("cn_new_inst_rdata", 64'(inst_rdata), 64'(32'h3333_4444));
    step(); clearInputs(); #1;
  endtask

  task automatic resetMidFlight();
    step(); data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_2000; #1;
    step(); #1;
    checkEq("rm_pre_bus_req", 64'(bus_req), 64'(1'b1));
    step(); rst = 1'b1; #1;
    checkEq("rm_rst_bus_req", 64'(bus_req), 64'(1'b0));
    step(); rst = 1'b0; data_req = 1'b0; #1;
    checkEq("rm_post_bus_req", 64'(bus_req), 64'(1'b0));
    step(); bus_data_ok = 1'b1; bus_rdata = 32'h5555_AAAA; #1;
    checkEq("rm_late_data_valid", 64'(data_valid), 64'(1'b0));
    checkEq("rm_late_inst_valid", 64'(inst_valid), 64'(1'b0));
    step(); clearInputs(); #1;
  endtask

  task automatic randomTraffic(input int cycles);
    logic fActive = 1'b0;
    logic dActive = 1'b0;
    logic sOut = 1'b0;
    logic pInstValid = 1'b0;
    logic pDataValid = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (rst) sOut = 1'b0;
      else if (bus_addr_ok) sOut = 1'b1;
      else if (bus_data_ok && sOut) sOut = 1'b0;

      if (pInstValid) fActive = 1'b0;
      if (pDataValid) dActive = 1'b0;

      inst_cancel = 1'b0;
      if (fActive && $urandom_range(0, 11) == 0) begin
        inst_cancel = 1'b1;
        fActive = 1'b0;
      end else if (!fActive) begin
        if ($urandom_range(0, 2) == 0) begin
          fActive = 1'b1;
          inst_addr = $urandom & 32'hFFFF_FFFC;
        end else if ($urandom_range(0, 19) == 0) begin
          inst_cancel = 1'b1;
        end
      end
      inst_req = fActive;

      if (!dActive && $urandom_range(0, 3) == 0) begin
        dActive = 1'b1;
        data_wr = 1'($urandom_range(0, 1));
        data_wstrb = 4'($urandom);
        data_addr = $urandom & 32'hFFFF_FFFC;
        data_wdata = $urandom;
      end
      data_req = dActive;

      rst = ($urandom_range(0, 299) == 0);
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata = $urandom;
      if (!rst) begin
        if (sOut) begin
          bus_data_ok = ($urandom_range(0, 2) == 0);
        end else if (bus_req) begin
          bus_addr_ok = ($urandom_range(0, 1) == 0);
          if (!bus_addr_ok && $urandom_range(0, 7) == 0) bus_data_ok = 1'b1;
        end else begin
          bus_data_ok = ($urandom_range(0, 9) == 0);
        end
      end
      #1;
      pInstValid = inst_valid;
      pDataValid = data_valid;
    end
    step(); clearInputs(); rst = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    @(posedge clk);
    #2;
    checkEq("reset_bus_req", 64'(bus_req), 64'(1'b0));
    checkEq("reset_bus_addr", 64'(bus_addr), 64'(32'h0));
    checkEq("reset_bus_wdata", 64'(bus_wdata), 64'(32'h0));
    checkEq("reset_inst_valid", 64'(inst_valid), 64'(1'b0));
    checkEq("reset_data_valid", 64'(data_valid), 64'(1'b0));
    step();
    rst = 1'b0;
    step();
    fetchAlone();
    contention();
    storeSlowAccept();
    cancelFetch();
    resetMidFlight();
    randomTraffic(4000);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
